jtag_tap_param: RTL and testbench
=================================

JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

Interface
REQ-001 Parameter IR_W, default 4, instruction register width (>=2).
REQ-002 Parameter NUM_DR, default 2, number of user data registers (1..(2**IR_W)-3).
REQ-003 Parameter DR_W, default 8, width of each user data register.
REQ-004 Parameter IDCODE_VAL, default 32'h1000_0001, 32-bit device ID (bit 0 SHALL be 1).
REQ-005 TCLK  input  1  sole clock; all state on rising edge except TDO/tdo_en on falling edge.
REQ-006 TRST  input  1  asynchronous, active-low reset.
REQ-007 TMS  input  1  test mode select, sampled on TCLK rising edge.
REQ-008 TDI  input  1  serial data in, sampled on TCLK rising edge.
REQ-009 TDO  output  1  serial data out.
REQ-010 tdo_en  output  1  high while TDO carries valid shift data.
REQ-011 dr_cap_in  input  NUM_DR*DR_W  parallel capture value; slice k = user DR k.
REQ-012 dr_upd_out  output  NUM_DR*DR_W  parallel update registers; slice k = user DR k.
REQ-013 dr_upd_stb  output  NUM_DR  one-cycle pulse on update of user DR k.
REQ-014 ir_out  output  IR_W  current (updated) instruction.
REQ-015 tap_state  output  4  current TAP state encoding.

Function
REQ-016 TAP FSM SHALL implement all 16 IEEE 1149.1 states with encodings: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
REQ-017 Transitions SHALL follow 1149.1 exactly on TMS at each rising edge; five consecutive TMS=1 edges from any state SHALL reach TLR.
REQ-018 Instruction decode: all-ones = BYPASS; 1 = IDCODE; 2..NUM_DR+1 = USER(k = code-2); all other codes SHALL select BYPASS.
REQ-019 IR shift register: CapIR loads {0..0,01}; ShIR shifts right, TDI into MSB; UpdIR copies shift register to ir_out.
REQ-020 In TLR, ir_out SHALL be IDCODE (1) synchronously each cycle in TLR.
REQ-021 Data path selected by ir_out: bypass (1 bit), idcode (32 bits), or user DR k (DR_W bits).
REQ-022 CapDR: bypass loads 0; idcode loads IDCODE_VAL; user DR k loads dr_cap_in slice k.
REQ-023 ShDR: selected register shifts right, TDI into MSB, one bit per rising edge; unselected registers hold.
REQ-024 UpdDR with USER(k): dr_upd_out slice k <= shift register k; dr_upd_stb[k] high for exactly that one cycle; other slices hold.
REQ-025 UpdDR with BYPASS/IDCODE: no dr_upd_out change, no strobe.
REQ-026 TDO SHALL update on falling edge: in ShIR, IR shift LSB; in ShDR, selected DR LSB; tdo_en=1 in those states, else TDO=0, tdo_en=0.
REQ-027 Pause/Exit states SHALL hold all shift registers; re-entering ShDR/ShIR continues without recapture.
REQ-028 Shift register length SHALL be exact: N shifts of an N-bit DR return the captured value on TDO LSB-first with TDI bits emerging after N cycles.
REQ-029 ir_out changes only in UpdIR or TLR; a new instruction never alters an in-progress DR scan.

Reset
REQ-030 TRST low SHALL asynchronously force tap_state=TLR, ir_out=1, IR/DR shift registers=0, dr_upd_out=0, dr_upd_stb=0, TDO=0, tdo_en=0.
REQ-031 TRST deassertion mid-scan SHALL resume from TLR; no partial update SHALL occur.
REQ-032 TRST assertion during UpdDR SHALL suppress the strobe and leave dr_upd_out at 0.

Verification
REQ-033 Reset then TLR->RTI->SelDR->CapDR->ShDR, 32 shifts -> TDO emits 0x10000001 LSB-first, tdo_en=1 throughout.
REQ-034 Load IR all-ones, DR scan TDI=1,0,1,1 -> TDO = 0,1,0,1 (one-cycle bypass delay).
REQ-035 Load IR=2, dr_cap_in slice0=0xA5, shift 0x3C -> TDO 0xA5 LSB-first, dr_upd_out slice0=0x3C, dr_upd_stb=01 one cycle.
REQ-036 IR scan -> captured TDO bits 1,0,0,0 (IR_W=4); unused code 0x6 -> BYPASS behaviour.
REQ-037 From each of 16 states, TMS=1 x5 -> tap_state=F; ShDR interrupted by Ex1->Pause->Ex2->ShDR preserves data.
REQ-038 TRST pulse mid ShDR and during UpdDR -> all outputs at reset values immediately, no strobe.

Source files
------------

// File: rtl/jtag_tap_param.sv
// IEEE 1149.1 TAP controller with IDCODE, BYPASS and NUM_DR user data registers.
// All state moves on TCLK rise; TDO/tdo_en launch on TCLK fall.

module jtag_tap_udr #(
    parameter int DR_W = 8
) (
    input  logic            tclk,
    input  logic            trst_n,
    input  logic            sel,
    input  logic            capture,
    input  logic            shift,
    input  logic            update,
    input  logic            tdi,
    input  logic [DR_W-1:0] cap_val,
    output logic            lsb,
    output logic [DR_W-1:0] upd_val,
    output logic            upd_stb
);
    logic [DR_W-1:0] sr;

    always_ff @(posedge tclk or negedge trst_n) begin
        if (!trst_n) begin
            sr      <= '0;
            upd_val <= '0;
            upd_stb <= 1'b0;
        end else begin
            upd_stb <= 1'b0;
            if (sel) begin
                if (capture)
                    sr <= cap_val;
                else if (shift)
                    sr <= (sr >> 1) | (DR_W'(tdi) << (DR_W - 1));
                if (update) begin
                    upd_val <= sr;
                    upd_stb <= 1'b1;
                end
            end
        end
    end

    assign lsb = sr[0];
endmodule

module jtag_tap_param #(
    parameter int          IR_W       = 4,
    parameter int          NUM_DR     = 2,
    parameter int          DR_W       = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                     TCLK,
    input  logic                     TRST,
    input  logic                     TMS,
    input  logic                     TDI,
    output logic                     TDO,
    output logic                     tdo_en,
    input  logic [NUM_DR*DR_W-1:0]   dr_cap_in,
    output logic [NUM_DR*DR_W-1:0]   dr_upd_out,
    output logic [NUM_DR-1:0]        dr_upd_stb,
    output logic [IR_W-1:0]          ir_out,
    output logic [3:0]               tap_state
);
    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    typedef enum logic [1:0] {SEL_BYP, SEL_ID, SEL_USR} dr_sel_e;

    tap_state_e state, state_nxt;
    dr_sel_e    dr_sel;

    logic [IR_W-1:0]   ir_sr;
    logic              byp_sr;
    logic [31:0]       id_sr;
    logic [NUM_DR-1:0] usr_sel;
    logic [NUM_DR-1:0] usr_lsb;
    logic              dr_lsb;
    logic              cap_dr, sh_dr, upd_dr;

    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) state <= TLR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            TLR:    state_nxt = TMS ? TLR    : RTI;
            RTI:    state_nxt = TMS ? SEL_DR : RTI;
            SEL_DR: state_nxt = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_nxt = TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_nxt = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = TMS ? SEL_DR : RTI;
            SEL_IR: state_nxt = TMS ? TLR    : CAP_IR;
            CAP_IR: state_nxt = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_nxt = TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_nxt = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = TMS ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    assign tap_state = state;
    assign cap_dr    = (state == CAP_DR);
    assign sh_dr     = (state == SH_DR);
    assign upd_dr    = (state == UPD_DR);

    // ir_out only moves in UpdIR or TLR, so the DR path stays fixed across a whole DR scan.
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            ir_sr  <= '0;
            ir_out <= IR_W'(1);
        end else begin
            if (state == CAP_IR)
                ir_sr <= IR_W'(1);
            else if (state == SH_IR)
                ir_sr <= {TDI, ir_sr[IR_W-1:1]};
            if (state == TLR)
                ir_out <= IR_W'(1);
            else if (state == UPD_IR)
                ir_out <= ir_sr;
        end
    end

    // User codes 2..NUM_DR+1 never reach all-ones given the NUM_DR bound.
    always_comb begin
        dr_sel = SEL_BYP;
        if (&ir_out)
            dr_sel = SEL_BYP;
        else if (ir_out == IR_W'(1))
            dr_sel = SEL_ID;
        else if (|usr_sel)
            dr_sel = SEL_USR;
    end

    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            byp_sr <= 1'b0;
            id_sr  <= '0;
        end else begin
            if (dr_sel == SEL_BYP) begin
                if (cap_dr)     byp_sr <= 1'b0;
                else if (sh_dr) byp_sr <= TDI;
            end
            if (dr_sel == SEL_ID) begin
                if (cap_dr)     id_sr <= IDCODE_VAL;
                else if (sh_dr) id_sr <= {TDI, id_sr[31:1]};
            end
        end
    end

    for (genvar k = 0; k < NUM_DR; k++) begin : g_udr
        assign usr_sel[k] = (ir_out == IR_W'(k + 2));

        jtag_tap_udr #(.DR_W(DR_W)) u_udr (
            .tclk    (TCLK),
            .trst_n  (TRST),
            .sel     (usr_sel[k]),
            .capture (cap_dr),
            .shift   (sh_dr),
            .update  (upd_dr),
            .tdi     (TDI),
            .cap_val (dr_cap_in[k*DR_W +: DR_W]),
            .lsb     (usr_lsb[k]),
            .upd_val (dr_upd_out[k*DR_W +: DR_W]),
            .upd_stb (dr_upd_stb[k])
        );
    end

    always_comb begin
        dr_lsb = byp_sr;
        unique case (dr_sel)
            SEL_ID:  dr_lsb = id_sr[0];
            SEL_USR: dr_lsb = |(usr_lsb & usr_sel);
            default: dr_lsb = byp_sr;
        endcase
    end

    always_ff @(negedge TCLK or negedge TRST) begin
        if (!TRST) begin
            TDO    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            unique case (state)
                SH_IR: begin
                    TDO    <= ir_sr[0];
                    tdo_en <= 1'b1;
                end
                SH_DR: begin
                    TDO    <= dr_lsb;
                    tdo_en <= 1'b1;
                end
                default: begin
                    TDO    <= 1'b0;
                    tdo_en <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param: FSM walk, IR/DR scans, pause resume, TRST behaviour.

module tb_jtag_tap_param;
    localparam int IR_W   = 4;
    localparam int NUM_DR = 2;
    localparam int DR_W   = 8;

    logic TCLK = 1'b0;
    logic TRST = 1'b0;
    logic TMS  = 1'b1;
    logic TDI  = 1'b0;
    logic TDO, tdo_en;
    logic [NUM_DR*DR_W-1:0] dr_cap_in = '0;
    logic [NUM_DR*DR_W-1:0] dr_upd_out;
    logic [NUM_DR-1:0]      dr_upd_stb;
    logic [IR_W-1:0]        ir_out;
    logic [3:0]             tap_state;

    int errors = 0;
    int checks = 0;

    jtag_tap_param #(
        .IR_W(IR_W), .NUM_DR(NUM_DR), .DR_W(DR_W), .IDCODE_VAL(32'h1000_0001)
    ) dut (
        .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
        .dr_cap_in(dr_cap_in), .dr_upd_out(dr_upd_out), .dr_upd_stb(dr_upd_stb),
        .ir_out(ir_out), .tap_state(tap_state)
    );

    always #5 TCLK = ~TCLK;

    // Inputs change just after the falling edge; outputs are read there too.
    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCLK);
        @(negedge TCLK);
        #1;
    endtask

    task automatic do_reset();
        TRST = 1'b0; TMS = 1'b1; TDI = 1'b0;
        #3;
        TRST = 1'b1;
        @(negedge TCLK);
        #1;
    endtask

    task automatic to_shdr();
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    endtask

    task automatic to_upd();
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    endtask

    task automatic shift_bits(input int n, input logic [63:0] din,
                              output logic [63:0] dout, output logic en_ok);
        dout  = '0;
        en_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            dout[i] = TDO;
            if (tdo_en !== 1'b1) en_ok = 1'b0;
            tick(i == n - 1, din[i]);
        end
    endtask

    task automatic load_ir(input logic [IR_W-1:0] v, output logic [IR_W-1:0] cap);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int i = 0; i < IR_W; i++) begin
            cap[i] = TDO;
            tick(i == IR_W - 1, v[i]);
        end
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge TCLK); #1;
        checks += 6;
        if (tap_state !== 4'hF) begin errors++; $display("FAIL rst_state: got %h want f", tap_state); end
        if (ir_out !== 4'h1) begin errors++; $display("FAIL rst_ir: got %h want 1", ir_out); end
        if (TDO !== 1'b0) begin errors++; $display("FAIL rst_tdo: got %b want 0", TDO); end
        if (tdo_en !== 1'b0) begin errors++; $display("FAIL rst_tdo_en: got %b want 0", tdo_en); end
        if (dr_upd_out !== 16'h0) begin errors++; $display("FAIL rst_upd: got %h want 0", dr_upd_out); end
        if (dr_upd_stb !== 2'b00) begin errors++; $display("FAIL rst_stb: got %b want 00", dr_upd_stb); end
        TRST = 1'b1;
        tick(1'b0, 1'b0);
        checks++;
        if (tap_state !== 4'hC) begin errors++; $display("FAIL rst_to_rti: got %h want c", tap_state); end
        TRST = 1'b0;
        #1;
        checks++;
        if (tap_state !== 4'hF) begin errors++; $display("FAIL rst_async: got %h want f", tap_state); end
        #1;
        TRST = 1'b1;
        tick(1'b1, 1'b0);
    endtask

    task automatic test_idcode();
        logic [63:0] dout;
        logic en;
        do_reset();
        tick(1'b0, 1'b0);
        to_shdr();
        checks++;
        if (tap_state !== 4'h2) begin errors++; $display("FAIL id_shdr: got %h want 2", tap_state); end
        shift_bits(32, 64'h0, dout, en);
        checks += 3;
        if (dout[31:0] !== 32'h1000_0001) begin errors++; $display("FAIL idcode: got %h want 10000001", dout[31:0]); end
        if (en !== 1'b1) begin errors++; $display("FAIL id_tdo_en: got %b want 1", en); end
        if (tdo_en !== 1'b0) begin errors++; $display("FAIL id_ex1_en: got %b want 0", tdo_en); end
        to_upd();
    endtask

    task automatic test_bypass();
        logic [63:0] dout;
        logic en;
        logic [IR_W-1:0] cap;
        do_reset();
        tick(1'b0, 1'b0);
        load_ir(4'hF, cap);
        checks++;
        if (ir_out !== 4'hF) begin errors++; $display("FAIL byp_ir: got %h want f", ir_out); end
        to_shdr();
        shift_bits(4, 64'b1101, dout, en);
        to_upd();
        checks += 3;
        if (dout[3:0] !== 4'b1010) begin errors++; $display("FAIL bypass: got %b want 1010", dout[3:0]); end
        if (dr_upd_stb !== 2'b00) begin errors++; $display("FAIL byp_stb: got %b want 00", dr_upd_stb); end
        if (dr_upd_out !== 16'h0) begin errors++; $display("FAIL byp_upd: got %h want 0", dr_upd_out); end
    endtask

    task automatic test_user();
        logic [63:0] dout;
        logic en;
        logic [IR_W-1:0] cap;
        do_reset();
        tick(1'b0, 1'b0);
        dr_cap_in = {8'h77, 8'hA5};
        load_ir(4'h2, cap);
        checks += 2;
        if (cap !== 4'b0001) begin errors++; $display("FAIL ir_capture: got %b want 0001", cap); end
        if (ir_out !== 4'h2) begin errors++; $display("FAIL usr0_ir: got %h want 2", ir_out); end
        to_shdr();
        shift_bits(8, 64'h3C, dout, en);
        tick(1'b1, 1'b0);
        checks += 3;
        if (dout[7:0] !== 8'hA5) begin errors++; $display("FAIL usr0_tdo: got %h want a5", dout[7:0]); end
        if (tap_state !== 4'h5) begin errors++; $display("FAIL usr0_upd_state: got %h want 5", tap_state); end
        if (dr_upd_stb !== 2'b00) begin errors++; $display("FAIL usr0_stb_early: got %b want 00", dr_upd_stb); end
        tick(1'b0, 1'b0);
        checks += 2;
        if (dr_upd_stb !== 2'b01) begin errors++; $display("FAIL usr0_stb: got %b want 01", dr_upd_stb); end
        if (dr_upd_out !== 16'h003C) begin errors++; $display("FAIL usr0_upd: got %h want 003c", dr_upd_out); end
        tick(1'b0, 1'b0);
        checks++;
        if (dr_upd_stb !== 2'b00) begin errors++; $display("FAIL usr0_stb_len: got %b want 00", dr_upd_stb); end
        load_ir(4'h3, cap);
        to_shdr();
        shift_bits(8, 64'h81, dout, en);
        to_upd();
        checks += 3;
        if (dout[7:0] !== 8'h77) begin errors++; $display("FAIL usr1_tdo: got %h want 77", dout[7:0]); end
        if (dr_upd_stb !== 2'b10) begin errors++; $display("FAIL usr1_stb: got %b want 10", dr_upd_stb); end
        if (dr_upd_out !== 16'h813C) begin errors++; $display("FAIL usr1_upd: got %h want 813c", dr_upd_out); end
        load_ir(4'h6, cap);
        checks++;
        if (ir_out !== 4'h6) begin errors++; $display("FAIL unused_ir: got %h want 6", ir_out); end
        to_shdr();
        shift_bits(3, 64'b011, dout, en);
        to_upd();
        checks += 3;
        if (dout[2:0] !== 3'b110) begin errors++; $display("FAIL unused_byp: got %b want 110", dout[2:0]); end
        if (dr_upd_stb !== 2'b00) begin errors++; $display("FAIL unused_stb: got %b want 00", dr_upd_stb); end
        if (dr_upd_out !== 16'h813C) begin errors++; $display("FAIL unused_upd: got %h want 813c", dr_upd_out); end
    endtask

    // Paths from TLR to every state, TMS bits listed LSB first.
    int         plen  [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    logic [7:0] pbits [16] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                               8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
    logic [3:0] ptgt  [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                               4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

    task automatic test_fsm();
        logic [7:0] bits;
        do_reset();
        for (int s = 0; s < 16; s++) begin
            bits = pbits[s];
            for (int i = 0; i < plen[s]; i++) tick(bits[i], 1'b0);
            checks++;
            if (tap_state !== ptgt[s]) begin errors++; $display("FAIL fsm_reach[%0d]: got %h want %h", s, tap_state, ptgt[s]); end
            for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
            checks++;
            if (tap_state !== 4'hF) begin errors++; $display("FAIL fsm_tlr5[%0d]: got %h want f", s, tap_state); end
        end
    endtask

    task automatic test_pause();
        logic [7:0] din, dout;
        logic [IR_W-1:0] cap;
        do_reset();
        tick(1'b0, 1'b0);
        dr_cap_in = {8'h00, 8'h5A};
        din = 8'hC3;
        dout = '0;
        load_ir(4'h2, cap);
        to_shdr();
        for (int i = 0; i < 4; i++) begin
            dout[i] = TDO;
            tick(i == 3, din[i]);
        end
        checks += 2;
        if (tap_state !== 4'h1) begin errors++; $display("FAIL pause_ex1: got %h want 1", tap_state); end
        if (tdo_en !== 1'b0) begin errors++; $display("FAIL pause_en: got %b want 0", tdo_en); end
        tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b1, 1'b1); tick(1'b0, 1'b1);
        checks++;
        if (tap_state !== 4'h2) begin errors++; $display("FAIL pause_reshdr: got %h want 2", tap_state); end
        for (int i = 4; i < 8; i++) begin
            dout[i] = TDO;
            tick(i == 7, din[i]);
        end
        to_upd();
        checks += 2;
        if (dout !== 8'h5A) begin errors++; $display("FAIL pause_tdo: got %h want 5a", dout); end
        if (dr_upd_out[7:0] !== 8'hC3) begin errors++; $display("FAIL pause_upd: got %h want c3", dr_upd_out[7:0]); end
    endtask

    task automatic test_trst_mid();
        logic [63:0] dout;
        logic en;
        logic [IR_W-1:0] cap;
        do_reset();
        tick(1'b0, 1'b0);
        dr_cap_in = {8'h11, 8'h22};
        load_ir(4'h2, cap);
        to_shdr();
        shift_bits(8, 64'h3C, dout, en);
        to_upd();
        checks++;
        if (dr_upd_out[7:0] !== 8'h3C) begin errors++; $display("FAIL mid_pre_upd: got %h want 3c", dr_upd_out[7:0]); end
        to_shdr();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        TRST = 1'b0;
        #1;
        checks += 6;
        if (tap_state !== 4'hF) begin errors++; $display("FAIL mid_state: got %h want f", tap_state); end
        if (TDO !== 1'b0) begin errors++; $display("FAIL mid_tdo: got %b want 0", TDO); end
        if (tdo_en !== 1'b0) begin errors++; $display("FAIL mid_en: got %b want 0", tdo_en); end
        if (ir_out !== 4'h1) begin errors++; $display("FAIL mid_ir: got %h want 1", ir_out); end
        if (dr_upd_out !== 16'h0) begin errors++; $display("FAIL mid_upd: got %h want 0", dr_upd_out); end
        if (dr_upd_stb !== 2'b00) begin errors++; $display("FAIL mid_stb: got %b want 00", dr_upd_stb); end
        #1;
        TRST = 1'b1;
        tick(1'b0, 1'b0);
        checks += 2;
        if (tap_state !== 4'hC) begin errors++; $display("FAIL mid_resume: got %h want c", tap_state); end
        if (dr_upd_out !== 16'h0) begin errors++; $display("FAIL mid_no_upd: got %h want 0", dr_upd_out); end
    endtask

    task automatic test_trst_upd();
        logic [63:0] dout;
        logic en;
        logic [IR_W-1:0] cap;
        do_reset();
        tick(1'b0, 1'b0);
        load_ir(4'h2, cap);
        to_shdr();
        shift_bits(8, 64'h99, dout, en);
        tick(1'b1, 1'b0);
        checks++;
        if (tap_state !== 4'h5) begin errors++; $display("FAIL upd_reach: got %h want 5", tap_state); end
        TRST = 1'b0;
        #1;
        checks += 3;
        if (tap_state !== 4'hF) begin errors++; $display("FAIL upd_rst_state: got %h want f", tap_state); end
        if (dr_upd_stb !== 2'b00) begin errors++; $display("FAIL upd_rst_stb: got %b want 00", dr_upd_stb); end
        if (dr_upd_out !== 16'h0) begin errors++; $display("FAIL upd_rst_out: got %h want 0", dr_upd_out); end
        @(posedge TCLK); #1;
        checks += 2;
        if (dr_upd_stb !== 2'b00) begin errors++; $display("FAIL upd_edge_stb: got %b want 00", dr_upd_stb); end
        if (dr_upd_out !== 16'h0) begin errors++; $display("FAIL upd_edge_out: got %h want 0", dr_upd_out); end
        @(negedge TCLK); #1;
        TRST = 1'b1;
        tick(1'b1, 1'b0);
        checks += 3;
        if (tap_state !== 4'hF) begin errors++; $display("FAIL upd_after_state: got %h want f", tap_state); end
        if (dr_upd_stb !== 2'b00) begin errors++; $display("FAIL upd_after_stb: got %b want 00", dr_upd_stb); end
        if (dr_upd_out !== 16'h0) begin errors++; $display("FAIL upd_after_out: got %h want 0", dr_upd_out); end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_bypass();
        test_user();
        test_fsm();
        test_pause();
        test_trst_mid();
        test_trst_upd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
